// File: rtl/mem_stage_ctrl_pkg.sv
// Shared ISA definitions and M/W payload type for the memory stage.
package mem_stage_ctrl_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned OPC_W   = 5;
    localparam int unsigned OPC_LSB = 27;

    localparam logic [OPC_W-1:0] OPC_LW = 5'b01000;
    localparam logic [OPC_W-1:0] OPC_SW = 5'b00111;
    localparam logic [XLEN-1:0]  NOP    = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] ir;
        logic [XLEN-1:0] o;
        logic [XLEN-1:0] d;
    } mw_payload_t;

    function automatic logic [OPC_W-1:0] opcode_of(input logic [XLEN-1:0] ir);
        return ir[XLEN-1:OPC_LSB];
    endfunction

    function automatic logic is_mem_op(input logic [XLEN-1:0] ir);
        return (opcode_of(ir) == OPC_LW) || (opcode_of(ir) == OPC_SW);
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_mw_latch.sv
// M/W pipeline register: loads the payload when enabled, or a nop bubble when bubble is set.
module mw_latch
    import mem_stage_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        bubble,
    input  mw_payload_t d,
    output mw_payload_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            if (bubble) begin
                q.ir <= NOP;
                q.o  <= '0;
                q.d  <= '0;
            end else begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory stage control: lw/sw req/ack handshake with a variable-latency data memory,
// upstream stall generation and M/W register sequencing.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   xm_ir,
    input  logic [XLEN-1:0]   xm_O,
    input  logic [XLEN-1:0]   xm_B,
    output logic              mem_stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic [XLEN-1:0]   dmem_rdata,
    input  logic              dmem_ack,
    output logic [XLEN-1:0]   mw_ir,
    output logic [XLEN-1:0]   mw_O,
    output logic [XLEN-1:0]   mw_D,
    output logic              mem_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    state_t          state;
    logic [CNT_W-1:0] wait_cnt;
    logic [XLEN-1:0]  load_data;

    logic        is_mem_c;
    logic        is_sw_c;
    logic        timeout_hit_c;
    logic        lat_en_c;
    logic        lat_bubble_c;
    logic [XLEN-1:0] lat_d_c;
    mw_payload_t mw_din_c;
    mw_payload_t mw_q;

    // Instruction decode and timeout detection
    always_comb begin
        is_mem_c      = is_mem_op(xm_ir);
        is_sw_c       = (opcode_of(xm_ir) == OPC_SW);
        timeout_hit_c = (TIMEOUT != 0) && (wait_cnt == CNT_W'(TO_LAST));
    end

    // Stall is combinational so the X/M latch holds in the same cycle the mem op appears
    always_comb begin
        mem_stall = 1'b0;
        case (state)
            ST_IDLE: mem_stall = is_mem_c;
            ST_REQ:  mem_stall = 1'b1;
            default: mem_stall = 1'b0;
        endcase
    end

    // M/W latch steering: bubbles while waiting, hold on the ack edge, retire in DONE
    always_comb begin
        lat_en_c     = 1'b1;
        lat_bubble_c = 1'b0;
        lat_d_c      = '0;
        case (state)
            ST_IDLE: lat_bubble_c = is_mem_c;
            ST_REQ: begin
                lat_en_c     = ~dmem_ack;
                lat_bubble_c = 1'b1;
            end
            ST_DONE: lat_d_c = load_data;
            default: lat_bubble_c = 1'b1;
        endcase
        mw_din_c = '{ir: xm_ir, o: xm_O, d: lat_d_c};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            load_data  <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            mem_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (is_mem_c) begin
                        state      <= ST_REQ;
                        wait_cnt   <= '0;
                        dmem_req   <= 1'b1;
                        dmem_we    <= is_sw_c;
                        dmem_addr  <= xm_O[ADDR_W-1:0];
                        dmem_wdata <= xm_B;
                    end
                end
                ST_REQ: begin
                    if (dmem_ack) begin
                        dmem_req  <= 1'b0;
                        load_data <= dmem_we ? '0 : dmem_rdata;
                        state     <= ST_DONE;
                    end else if (timeout_hit_c) begin
                        dmem_req  <= 1'b0;
                        mem_err   <= 1'b1;
                        load_data <= '0;
                        state     <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    mw_latch u_mw_latch (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (lat_en_c),
        .bubble (lat_bubble_c),
        .d      (mw_din_c),
        .q      (mw_q)
    );

    always_comb begin
        mw_ir = mw_q.ir;
        mw_O  = mw_q.o;
        mw_D  = mw_q.d;
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench: an instruction-level model expands each op into its expected per-cycle timeline.
module tb_mem_stage_ctrl;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned TO     = 16;
    localparam logic [4:0]  LW     = 5'b01000;
    localparam logic [4:0]  SW     = 5'b00111;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [31:0]       xm_ir = '0, xm_O = '0, xm_B = '0;
    logic              mem_stall;
    logic              dmem_req, dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_wdata;
    logic [31:0]       dmem_rdata = '0;
    logic              dmem_ack = 1'b0;
    logic [31:0]       mw_ir, mw_O, mw_D;
    logic              mem_err;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .xm_ir      (xm_ir),
        .xm_O       (xm_O),
        .xm_B       (xm_B),
        .mem_stall  (mem_stall),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .mw_ir      (mw_ir),
        .mw_O       (mw_O),
        .mw_D       (mw_D),
        .mem_err    (mem_err)
    );

    typedef struct {
        logic [31:0] ir, o, b, rdata;
        logic        ack;
        logic        stall, req, we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] mw_ir, mw_o, mw_d;
        logic        mw_chk;
    } cyc_t;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] val;
    } pin_t;

    cyc_t tl[$];
    pin_t pins[$];

    logic [31:0] m_ir, m_o, m_d;
    logic        m_chk, m_err;

    int checks = 0;
    int failures = 0;
    bit go = 0;
    bit cmp_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] ir, o, b, input logic ack, input logic [31:0] rd,
                        input logic stall, req, we, input logic [11:0] addr, input logic [31:0] wdata);
        cyc_t c;
        c.ir = ir; c.o = o; c.b = b; c.ack = ack; c.rdata = rd;
        c.stall = stall; c.req = req; c.we = we; c.addr = addr; c.wdata = wdata;
        c.err = m_err;
        c.mw_ir = m_ir; c.mw_o = m_o; c.mw_d = m_d; c.mw_chk = m_chk;
        tl.push_back(c);
    endtask

    function automatic logic stray();
        return ($urandom_range(0, 3) == 0);
    endfunction

    // Non-memory op: one cycle, no stall, retires with D=0
    task automatic gen_alu(input logic [31:0] ir, o, b);
        push(ir, o, b, stray(), $urandom | 32'h1, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
        m_ir = ir; m_o = o; m_d = '0; m_chk = 1'b1;
    endtask

    // Memory op: IDLE (stall), REQ cycles until ack (k) or timeout, then DONE retire
    task automatic gen_mem(input logic [31:0] ir, o, b, input int k, input logic [31:0] rd,
                           input logic stray_done, output int idle_cyc);
        logic        is_lw;
        logic [31:0] ld;
        is_lw = (ir[31:27] == LW);
        ld = '0;
        idle_cyc = tl.size();
        push(ir, o, b, stray(), $urandom | 32'h1, 1'b1, 1'b0, 1'b0, 12'h0, 32'h0);
        m_ir = '0; m_chk = 1'b0;
        for (int j = 0; j < 1000; j++) begin
            if (j == k) begin
                push(ir, o, b, 1'b1, rd, 1'b1, 1'b1, ~is_lw, o[11:0], b);
                ld = is_lw ? rd : 32'h0;
                break;
            end
            push(ir, o, b, 1'b0, $urandom, 1'b1, 1'b1, ~is_lw, o[11:0], b);
            m_ir = '0; m_chk = 1'b0;
            if (TO != 0 && j == int'(TO) - 1) begin
                m_err = 1'b1;
                ld = '0;
                break;
            end
        end
        push(ir, o, b, stray_done, $urandom | 32'h1, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
        m_ir = ir; m_o = o; m_d = ld; m_chk = 1'b1;
    endtask

    task automatic pin(input int cyc, input int sig, input logic [31:0] val);
        pin_t p;
        p.cyc = cyc; p.sig = sig; p.val = val;
        pins.push_back(p);
    endtask

    function automatic logic [31:0] sig_val(input int sig);
        case (sig)
            0:       return {31'h0, mem_stall};
            1:       return {31'h0, dmem_req};
            2:       return {20'h0, dmem_addr};
            3:       return dmem_wdata;
            4:       return {31'h0, dmem_we};
            5:       return mw_D;
            6:       return mw_O;
            default: return {31'h0, mem_err};
        endcase
    endfunction

    // Compare process: every timeline cycle, sampled mid-cycle
    initial begin
        wait (go);
        for (int c = 0; c < tl.size(); c++) begin
            @(negedge clk);
            check($sformatf("stall@%0d", c), {31'h0, mem_stall}, {31'h0, tl[c].stall});
            check($sformatf("req@%0d", c), {31'h0, dmem_req}, {31'h0, tl[c].req});
            check($sformatf("err@%0d", c), {31'h0, mem_err}, {31'h0, tl[c].err});
            check($sformatf("mw_ir@%0d", c), mw_ir, tl[c].mw_ir);
            if (tl[c].req) begin
                check($sformatf("we@%0d", c), {31'h0, dmem_we}, {31'h0, tl[c].we});
                check($sformatf("addr@%0d", c), {20'h0, dmem_addr}, {20'h0, tl[c].addr});
                check($sformatf("wdata@%0d", c), dmem_wdata, tl[c].wdata);
            end
            if (tl[c].mw_chk) begin
                check($sformatf("mw_O@%0d", c), mw_O, tl[c].mw_o);
                check($sformatf("mw_D@%0d", c), mw_D, tl[c].mw_d);
            end
            foreach (pins[p]) begin
                if (pins[p].cyc == c)
                    check($sformatf("pin%0d_sig%0d@%0d", p, pins[p].sig, c), sig_val(pins[p].sig), pins[p].val);
            end
        end
        cmp_done = 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, l_i, s_i, t_i, bb;
        int k;
        logic [4:0] op;
        logic [31:0] ir, o, b;
        logic got;

        // Reset state
        #12;
        check("rst_stall", {31'h0, mem_stall}, 32'h0);
        check("rst_req", {31'h0, dmem_req}, 32'h0);
        check("rst_we", {31'h0, dmem_we}, 32'h0);
        check("rst_addr", {20'h0, dmem_addr}, 32'h0);
        check("rst_wdata", dmem_wdata, 32'h0);
        check("rst_mw_ir", mw_ir, 32'h0);
        check("rst_mw_O", mw_O, 32'h0);
        check("rst_mw_D", mw_D, 32'h0);
        check("rst_err", {31'h0, mem_err}, 32'h0);

        m_ir = '0; m_o = '0; m_d = '0; m_chk = 1'b1; m_err = 1'b0;

        // Directed program
        a = tl.size();
        gen_alu({5'b00000, 27'h0000021}, 32'h5, 32'h9);
        gen_mem({LW, 27'h0000101}, 32'h104, 32'h0BAD_0BAD, 0, 32'hDEADBEEF, 1'b0, l_i);
        gen_mem({SW, 27'h0000202}, 32'h20, 32'h1234, 5, 32'h0, 1'b0, s_i);
        gen_mem({LW, 27'h0000303}, 32'hABCD_E123, 32'h7, 99, 32'h0, 1'b1, t_i);
        gen_mem({LW, 27'h0000404}, 32'h0000_0F0F, 32'h1, 2, 32'hCAFE_F00D, 1'b1, bb);
        gen_mem({SW, 27'h0000505}, 32'h0000_0ABC, 32'h5555_AAAA, 0, 32'h1111_2222, 1'b1, bb);

        pin(a, 0, 32'h0);
        pin(a + 1, 6, 32'h5);
        pin(a + 1, 5, 32'h0);
        pin(l_i, 0, 32'h1);
        pin(l_i + 1, 1, 32'h1);
        pin(l_i + 1, 2, 32'h104);
        pin(l_i + 1, 4, 32'h0);
        pin(l_i + 2, 0, 32'h0);
        pin(l_i + 2, 1, 32'h0);
        pin(l_i + 3, 5, 32'hDEADBEEF);
        pin(l_i + 3, 6, 32'h104);
        pin(s_i + 1, 4, 32'h1);
        pin(s_i + 1, 3, 32'h1234);
        pin(s_i + 6, 3, 32'h1234);
        pin(s_i + 6, 1, 32'h1);
        pin(s_i + 7, 0, 32'h0);
        pin(s_i + 7, 1, 32'h0);
        pin(s_i + 8, 5, 32'h0);
        pin(t_i + 1, 2, 32'h123);
        pin(t_i + 16, 1, 32'h1);
        pin(t_i + 16, 7, 32'h0);
        pin(t_i + 17, 1, 32'h0);
        pin(t_i + 17, 7, 32'h1);
        pin(t_i + 18, 5, 32'h0);

        // Randomized program
        repeat (60) begin
            o = $urandom;
            b = $urandom;
            case ($urandom_range(0, 9))
                0, 1, 2, 3: op = LW;
                4, 5:       op = SW;
                default: begin
                    op = 5'($urandom);
                    if (op == LW || op == SW) op = 5'h1F;
                end
            endcase
            ir = {op, 27'($urandom)};
            if (op == LW || op == SW) begin
                k = ($urandom_range(0, 9) == 0) ? 99 : int'($urandom_range(0, 6));
                gen_mem(ir, o, b, k, $urandom, stray(), bb);
            end else begin
                gen_alu(ir, o, b);
            end
        end

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < tl.size(); c++) begin
            xm_ir = tl[c].ir;
            xm_O = tl[c].o;
            xm_B = tl[c].b;
            dmem_ack = tl[c].ack;
            dmem_rdata = tl[c].rdata;
            go = 1;
            @(posedge clk);
            #1;
        end
        check("timeline_complete", {31'h0, cmp_done}, 32'h1);

        // Asynchronous reset in the middle of a request
        xm_ir = {SW, 27'h5};
        xm_O = 32'h3FF;
        xm_B = 32'h55;
        dmem_ack = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk);
            #1;
            got = dmem_req;
        end
        check("midreq_req_seen", {31'h0, got}, 32'h1);
        #2;
        rst_n = 1'b0;
        xm_ir = 32'h0;
        #1;
        check("midrst_req", {31'h0, dmem_req}, 32'h0);
        check("midrst_we", {31'h0, dmem_we}, 32'h0);
        check("midrst_addr", {20'h0, dmem_addr}, 32'h0);
        check("midrst_wdata", dmem_wdata, 32'h0);
        check("midrst_mw_ir", mw_ir, 32'h0);
        check("midrst_mw_O", mw_O, 32'h0);
        check("midrst_mw_D", mw_D, 32'h0);
        check("midrst_err", {31'h0, mem_err}, 32'h0);
        check("midrst_stall", {31'h0, mem_stall}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        xm_ir = {5'h02, 27'h3};
        xm_O = 32'h77;
        @(negedge clk);
        check("post_rst_stall", {31'h0, mem_stall}, 32'h0);
        @(posedge clk);
        #1;
        xm_ir = 32'h0;
        @(negedge clk);
        check("post_rst_mw_ir", mw_ir, {5'h02, 27'h3});
        check("post_rst_mw_O", mw_O, 32'h77);
        check("post_rst_mw_D", mw_D, 32'h0);
        check("post_rst_req", {31'h0, dmem_req}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
